// File: rtl/dsp_mac_seq.sv
// ---------------------------------------------------------------------------
// dsp_mac_seq
//   Upstream sequencer for a DSP slice. Accepts (A,B) operand beats over a
//   valid/ready handshake, drives the DSP A/B/opMode so the slice
//   multiply-accumulates the stream, and captures the final P once the beat
//   tagged inLast has drained through the DSP pipeline. The result is then
//   held behind a valid/ready handshake.
//
//   Optional feature macro: MAC_SEQ_OVF_EN
//     defined   -> resOvf is a sticky carry flag captured with the result
//     undefined -> resOvf is tied low and no sticky flop exists
//
// Ports
//   clk, rstN                 clock (rising edge), async active-low reset
//   inValid/inReady           operand beat handshake
//   inA, inB [17:0]           signed operands
//   inLast                    beat closes the current accumulation
//   dspA, dspB, dspOpMode     registered drive to the DSP slice
//   dspCE                     clock enable for every DSP register
//   dspP [47:0], dspCarryOut  DSP outputs
//   resValid/resReady         result handshake
//   resData [47:0], resOvf    held result and its carry flag
//   accCount [CNT_W-1:0]      beats in current accumulation (saturating)
// ---------------------------------------------------------------------------
module dsp_mac_seq #(
   parameter int DSP_LAT = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [17:0]      inA,
   input  logic [17:0]      inB,
   input  logic             inLast,
   output logic [17:0]      dspA,
   output logic [17:0]      dspB,
   output logic [7:0]       dspOpMode,
   output logic             dspCE,
   input  logic [47:0]      dspP,
   input  logic             dspCarryOut,
   output logic             resValid,
   input  logic             resReady,
   output logic [47:0]      resData,
   output logic             resOvf,
   output logic [CNT_W-1:0] accCount
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACC      = 2'd1,
      S_DRAIN    = 2'd2,
      S_HOLD_RES = 2'd3
   } state_t;

   localparam logic [7:0]       OP_FIRST = 8'h01;
   localparam logic [7:0]       OP_ACC   = 8'h09;
   localparam logic [7:0]       OP_HOLD  = 8'h08;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t             state_q, state_d;
   logic [17:0]        dspA_q, dspA_d;
   logic [17:0]        dspB_q, dspB_d;
   logic [7:0]         opMode_q, opMode_d;
   logic               dspCE_q;
   logic               last_q, last_d;
   logic [DSP_LAT-1:0] tok_q, tok_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               resValid_q, resValid_d;
   logic [47:0]        resData_q, resData_d;

   logic               accept_s;
   logic               capture_s;
   logic               handoff_s;

   // Ready depends on state only, never on inValid.
   assign inReady   = (state_q == S_IDLE) || (state_q == S_ACC);
   assign accept_s  = inValid && inReady;
   // The token leaves the pipe exactly when the last op's P is valid on dspP.
   assign capture_s = (state_q == S_DRAIN) && tok_q[DSP_LAT-1];
   assign handoff_s = (state_q == S_HOLD_RES) && resReady;

   // Next-state and next-output decode for the sequencer.
   always_comb begin
      state_d    = state_q;
      dspA_d     = 18'd0;
      dspB_d     = 18'd0;
      opMode_d   = OP_HOLD;
      last_d     = 1'b0;
      cnt_d      = cnt_q;
      resValid_d = resValid_q;
      resData_d  = resData_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               dspA_d   = inA;
               dspB_d   = inB;
               opMode_d = OP_FIRST;
               last_d   = inLast;
               cnt_d    = CNT_ONE;
               state_d  = inLast ? S_DRAIN : S_ACC;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_ACC: begin
            if (accept_s) begin
               dspA_d   = inA;
               dspB_d   = inB;
               opMode_d = OP_ACC;
               last_d   = inLast;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else begin
                  cnt_d = cnt_q;
               end
               state_d  = inLast ? S_DRAIN : S_ACC;
            end else begin
               // Bubble: HOLD with zero operands keeps P unchanged.
               state_d  = S_ACC;
            end
         end
         S_DRAIN: begin
            if (capture_s) begin
               resData_d  = dspP;
               resValid_d = 1'b1;
               state_d    = S_HOLD_RES;
            end else begin
               state_d    = S_DRAIN;
            end
         end
         S_HOLD_RES: begin
            if (handoff_s) begin
               resValid_d = 1'b0;
               cnt_d      = CNT_ZERO;
               state_d    = S_IDLE;
            end else begin
               state_d    = S_HOLD_RES;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Token pipe shifts behind the operand register stage, so it is
   // DSP_LAT stages past the edge that drove the last op.
   always_comb begin
      tok_d    = tok_q;
      tok_d[0] = last_q;
      for (int i = 1; i < DSP_LAT; i++) begin
         tok_d[i] = tok_q[i-1];
      end
   end

   // Sequencer state and all registered outputs.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= S_IDLE;
         dspA_q     <= 18'd0;
         dspB_q     <= 18'd0;
         opMode_q   <= OP_HOLD;
         dspCE_q    <= 1'b1;
         last_q     <= 1'b0;
         tok_q      <= {DSP_LAT{1'b0}};
         cnt_q      <= CNT_ZERO;
         resValid_q <= 1'b0;
         resData_q  <= 48'd0;
      end else begin
         state_q    <= state_d;
         dspA_q     <= dspA_d;
         dspB_q     <= dspB_d;
         opMode_q   <= opMode_d;
         dspCE_q    <= 1'b1;
         last_q     <= last_d;
         tok_q      <= tok_d;
         cnt_q      <= cnt_d;
         resValid_q <= resValid_d;
         resData_q  <= resData_d;
      end
   end

`ifdef MAC_SEQ_OVF_EN
   logic ovf_q, ovf_d;
   logic resOvf_q, resOvf_d;

   // Sticky carry over ACC/DRAIN cycles; snapshot taken alongside resData.
   always_comb begin
      ovf_d    = ovf_q;
      resOvf_d = resOvf_q;
      if ((state_q == S_IDLE) && accept_s) begin
         ovf_d = 1'b0;
      end else if ((state_q == S_ACC) || (state_q == S_DRAIN)) begin
         ovf_d = ovf_q | dspCarryOut;
      end else begin
         ovf_d = ovf_q;
      end
      if (capture_s) begin
         resOvf_d = ovf_q | dspCarryOut;
      end else begin
         resOvf_d = resOvf_q;
      end
   end

   // Carry flag registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ovf_q    <= 1'b0;
         resOvf_q <= 1'b0;
      end else begin
         ovf_q    <= ovf_d;
         resOvf_q <= resOvf_d;
      end
   end

   assign resOvf = resOvf_q;
`else
   logic unused_carry_s;
   assign unused_carry_s = dspCarryOut;
   assign resOvf         = 1'b0;
`endif

   assign dspA      = dspA_q;
   assign dspB      = dspB_q;
   assign dspOpMode = opMode_q;
   assign dspCE     = dspCE_q;
   assign resValid  = resValid_q;
   assign resData   = resData_q;
   assign accCount  = cnt_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_dsp_mac_seq
//   Directed bench for dsp_mac_seq with a behavioural DSP slice model
//   (accumulator + DSP_LAT-1 output stages, so an op driven after edge t
//   shows on dspP after edge t+DSP_LAT). Expected results are pushed to a
//   scoreboard when the last beat of an accumulation is sent and popped when
//   resValid rises.
// ---------------------------------------------------------------------------
module tb_dsp_mac_seq;
   localparam int DSP_LAT = 4;
   localparam int CNT_W   = 8;

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [17:0]      inA = 18'd0;
   logic [17:0]      inB = 18'd0;
   logic             inLast = 1'b0;
   logic [17:0]      dspA;
   logic [17:0]      dspB;
   logic [7:0]       dspOpMode;
   logic             dspCE;
   logic [47:0]      dspP;
   logic             dspCarryOut = 1'b0;
   logic             resValid;
   logic             resReady = 1'b0;
   logic [47:0]      resData;
   logic             resOvf;
   logic [CNT_W-1:0] accCount;

   dsp_mac_seq #(.DSP_LAT(DSP_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstN(rstN),
      .inValid(inValid), .inReady(inReady),
      .inA(inA), .inB(inB), .inLast(inLast),
      .dspA(dspA), .dspB(dspB), .dspOpMode(dspOpMode), .dspCE(dspCE),
      .dspP(dspP), .dspCarryOut(dspCarryOut),
      .resValid(resValid), .resReady(resReady),
      .resData(resData), .resOvf(resOvf), .accCount(accCount)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [47:0] prod48(input logic [17:0] a, input logic [17:0] b);
      logic signed [35:0] p;
      p = $signed(a) * $signed(b);
      return {{12{p[35]}}, p};
   endfunction

   // DSP slice model
   logic [47:0] acc_m;
   logic [47:0] p_pipe [DSP_LAT-1];
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         acc_m <= 48'd0;
         for (int i = 0; i < DSP_LAT-1; i++) p_pipe[i] <= 48'd0;
      end else begin
         case (dspOpMode)
            8'h01:   acc_m <= prod48(dspA, dspB);
            8'h09:   acc_m <= acc_m + prod48(dspA, dspB);
            default: acc_m <= acc_m;
         endcase
         p_pipe[0] <= acc_m;
         for (int i = 1; i < DSP_LAT-1; i++) p_pipe[i] <= p_pipe[i-1];
      end
   end
   assign dspP = p_pipe[DSP_LAT-2];

   typedef struct packed {
      logic [47:0]      data;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
   } exp_t;
   exp_t sb_q[$];

   int          tests = 0;
   int          fails = 0;
   logic [47:0] run_sum = 48'd0;
   int          run_cnt = 0;
   logic        ovf_exp = 1'b0;
   int          accept_cyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
      exp_t e;
      int   waited = 0;
      inValid = 1'b1; inA = a; inB = b; inLast = last;
      while (inReady !== 1'b1 && waited < 100) begin
         @(posedge clk); #1; waited++;
      end
      check("send_ready", inReady, 1'b1);
      @(posedge clk); #1;
      accept_cyc = cyc;
      inValid = 1'b0; inA = 18'd0; inB = 18'd0; inLast = 1'b0;
      run_sum = (run_cnt == 0) ? prod48(a, b) : run_sum + prod48(a, b);
      run_cnt++;
      if (last) begin
         e.data = run_sum;
         e.cnt  = (run_cnt > 255) ? 8'd255 : run_cnt[CNT_W-1:0];
         e.ovf  = ovf_exp;
         sb_q.push_back(e);
         run_cnt = 0;
      end
   endtask

   task automatic wait_result(input int exp_lat);
      exp_t e;
      int   guard = 0;
      while (resValid !== 1'b1 && guard < 60) begin
         @(posedge clk); #1; guard++;
      end
      check("res_valid_seen", resValid, 1'b1);
      if (exp_lat > 0) check("res_latency", cyc - accept_cyc, exp_lat);
      check("res_inready_low", inReady, 1'b0);
      check("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("res_data", resData, e.data);
         check("res_count", accCount, e.cnt);
         check("res_ovf", resOvf, e.ovf);
      end
   endtask

   task automatic release_result();
      resReady = 1'b1;
      @(posedge clk); #1;
      resReady = 1'b0;
      check("rel_valid", resValid, 1'b0);
      check("rel_inready", inReady, 1'b1);
      check("rel_count", accCount, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int highs;
      logic [47:0] held;

      // Reset state
      #12;
      check("rst_inready", inReady, 1'b1);
      check("rst_opmode", dspOpMode, 8'h08);
      check("rst_ce", dspCE, 1'b1);
      check("rst_dspA", dspA, 18'd0);
      check("rst_resvalid", resValid, 1'b0);
      check("rst_resdata", resData, 48'd0);
      check("rst_resovf", resOvf, 1'b0);
      check("rst_count", accCount, 0);
      #5 rstN = 1'b1;
      @(posedge clk); #1;

      // Single beat 20*10
      send_beat(18'd20, 18'd10, 1'b1);
      check("single_opmode", dspOpMode, 8'h01);
      check("single_dspA", dspA, 18'd20);
      check("single_count", accCount, 1);
      check("single_inready", inReady, 1'b0);
      wait_result(DSP_LAT + 1);
      check("single_data_const", resData, 48'd200);
      release_result();

      // Three back-to-back beats -> 68
      send_beat(18'd2, 18'd3, 1'b0);
      send_beat(18'd4, 18'd5, 1'b0);
      check("three_opmode_acc", dspOpMode, 8'h09);
      send_beat(18'd6, 18'd7, 1'b1);
      check("three_inready_after_last", inReady, 1'b0);
      wait_result(DSP_LAT + 1);
      check("three_data_const", resData, 48'd68);
      release_result();

      // Same beats with two bubbles after beat 1
      send_beat(18'd2, 18'd3, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("bubble_opmode", dspOpMode, 8'h08);
         check("bubble_dspA", dspA, 18'd0);
         check("bubble_inready", inReady, 1'b1);
      end
      send_beat(18'd4, 18'd5, 1'b0);
      send_beat(18'd6, 18'd7, 1'b1);
      wait_result(DSP_LAT + 1);
      check("bubble_data_const", resData, 48'd68);
      release_result();

      // Signed product held while resReady stays low
      send_beat(18'd3, 18'h3FFFC, 1'b1);
      wait_result(DSP_LAT + 1);
      held = resData;
      check("neg_data_const", held, 48'hFFFF_FFFF_FFF4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_valid", resValid, 1'b1);
         check("hold_data", resData, 48'hFFFF_FFFF_FFF4);
         check("hold_inready", inReady, 1'b0);
      end
      release_result();

      // Reset during drain aborts the accumulation
      send_beat(18'd9, 18'd9, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstN = 1'b0;
      #2;
      check("abort_resvalid", resValid, 1'b0);
      check("abort_inready", inReady, 1'b1);
      check("abort_count", accCount, 0);
      check("abort_opmode", dspOpMode, 8'h08);
      rstN = 1'b1;
      void'(sb_q.pop_back());  // (9,9) never produces a result
      highs = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (resValid !== 1'b0) highs++;
      end
      check("abort_no_result", highs, 0);
      send_beat(18'd1, 18'd1, 1'b1);
      check("after_abort_first", dspOpMode, 8'h01);
      wait_result(DSP_LAT + 1);
      check("after_abort_data_const", resData, 48'd1);
      release_result();

      // Carry seen during an ACC cycle
`ifdef MAC_SEQ_OVF_EN
      ovf_exp = 1'b1;
`else
      ovf_exp = 1'b0;
`endif
      send_beat(18'd2, 18'd3, 1'b0);
      dspCarryOut = 1'b1;
      @(posedge clk); #1;
      dspCarryOut = 1'b0;
      send_beat(18'd4, 18'd5, 1'b0);
      send_beat(18'd6, 18'd7, 1'b1);
      wait_result(DSP_LAT + 1);
      release_result();
      ovf_exp = 1'b0;
      send_beat(18'd1, 18'd2, 1'b1);
      wait_result(DSP_LAT + 1);
      check("noovf_flag", resOvf, 1'b0);
      release_result();

      // accCount saturation: 260 beats of 1*1
      for (int i = 0; i < 259; i++) send_beat(18'd1, 18'd1, 1'b0);
      check("sat_count_mid", accCount, 8'd255);
      send_beat(18'd1, 18'd1, 1'b1);
      wait_result(DSP_LAT + 1);
      check("sat_data_const", resData, 48'd260);
      release_result();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
